// File: rtl/pulse_train_gen.sv
// pulse_train_gen: multi-channel one-shot / continuous pulse-train generator.
// Ports:
//   clock, reset_n             system clock, async active-low reset
//   cfg_width, cfg_period      per-channel width / period, CNT_W bits each
//   cfg_mode                   per-channel 0 = one-shot, 1 = continuous
//   start, stop                per-channel start / abort requests
//   pulse, busy, done          per-channel outputs
// Build option: define PULSE_GEN_REG_OUT_EN to drive the outputs from flops,
// which adds exactly one cycle of latency to every output edge.
module pulse_train_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*CNT_W-1:0] cfg_width,
    input  logic [CHANNELS*CNT_W-1:0] cfg_period,
    input  logic [CHANNELS-1:0]       cfg_mode,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           r_state     [CHANNELS];
    state_t           w_state_nxt [CHANNELS];
    logic [CNT_W-1:0] r_cnt       [CHANNELS];
    logic [CNT_W-1:0] w_cnt_nxt   [CHANNELS];
    logic [CNT_W-1:0] r_w         [CHANNELS];
    logic [CNT_W-1:0] w_w_nxt     [CHANNELS];
    logic [CNT_W-1:0] r_p         [CHANNELS];
    logic [CNT_W-1:0] w_p_nxt     [CHANNELS];
    logic [CNT_W-1:0] w_cfg_w     [CHANNELS];
    logic [CNT_W-1:0] w_cfg_p     [CHANNELS];
    logic [CHANNELS-1:0] r_mode;
    logic [CHANNELS-1:0] w_mode_nxt;
    logic [CHANNELS-1:0] r_done;
    logic [CHANNELS-1:0] w_done_nxt;
    logic [CHANNELS-1:0] w_launch;
    logic [CHANNELS-1:0] w_pulse;
    logic [CHANNELS-1:0] w_busy;

    // Per-channel config slices; the latched period is clamped to the width
    // so a period shorter than the pulse still yields a well-formed train.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_cfg
            logic [CNT_W-1:0] w_raw_p;
            assign w_cfg_w[gi]  = cfg_width[gi*CNT_W +: CNT_W];
            assign w_raw_p      = cfg_period[gi*CNT_W +: CNT_W];
            assign w_cfg_p[gi]  = (w_raw_p > w_cfg_w[gi]) ? w_raw_p : w_cfg_w[gi];
            assign w_launch[gi] = start[gi] & ~stop[gi] & (|w_cfg_w[gi]);
        end
    endgenerate

    always_comb begin
        logic w_end;
        w_end = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_w_nxt[i]     = r_w[i];
            w_p_nxt[i]     = r_p[i];
            w_mode_nxt[i]  = r_mode[i];
            w_done_nxt[i]  = 1'b0;
            w_end          = 1'b0;
            unique case (r_state[i])
                S_IDLE: begin
                    if (w_launch[i]) begin
                        w_state_nxt[i] = S_HIGH;
                        w_cnt_nxt[i]   = CNT_W'(1);
                        w_w_nxt[i]     = w_cfg_w[i];
                        w_p_nxt[i]     = w_cfg_p[i];
                        w_mode_nxt[i]  = cfg_mode[i];
                    end
                end
                S_HIGH: begin
                    if (stop[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == r_w[i]) begin
                        if (r_p[i] > r_w[i]) begin
                            w_state_nxt[i] = S_LOW;
                            w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
                        end else begin
                            w_end = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (stop[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == r_p[i]) begin
                        w_end = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
            // A one-shot period end doubles as an idle slot, so a start seen
            // on that same edge restarts the channel without a dead cycle.
            if (w_end) begin
                if (r_mode[i]) begin
                    w_state_nxt[i] = S_HIGH;
                    w_cnt_nxt[i]   = CNT_W'(1);
                end else begin
                    w_done_nxt[i] = 1'b1;
                    if (w_launch[i]) begin
                        w_state_nxt[i] = S_HIGH;
                        w_cnt_nxt[i]   = CNT_W'(1);
                        w_w_nxt[i]     = w_cfg_w[i];
                        w_p_nxt[i]     = w_cfg_p[i];
                        w_mode_nxt[i]  = cfg_mode[i];
                    end else begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_w[i]     <= '0;
                r_p[i]     <= '0;
            end
            r_mode <= '0;
            r_done <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_w[i]     <= w_w_nxt[i];
                r_p[i]     <= w_p_nxt[i];
            end
            r_mode <= w_mode_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_pulse = '0;
        w_busy  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_pulse[i] = (r_state[i] == S_HIGH);
            w_busy[i]  = (r_state[i] != S_IDLE);
        end
    end

`ifdef PULSE_GEN_REG_OUT_EN
    logic [CHANNELS-1:0] r_pulse_q;
    logic [CHANNELS-1:0] r_busy_q;
    logic [CHANNELS-1:0] r_done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_q <= '0;
            r_busy_q  <= '0;
            r_done_q  <= '0;
        end else begin
            r_pulse_q <= w_pulse;
            r_busy_q  <= w_busy;
            r_done_q  <= r_done;
        end
    end

    assign pulse = r_pulse_q;
    assign busy  = r_busy_q;
    assign done  = r_done_q;
`else
    assign pulse = w_pulse;
    assign busy  = w_busy;
    assign done  = r_done;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: randomized and directed bench for pulse_train_gen.
// Reference model tracks each channel by start edge and elapsed time.
module tb_pulse_train_gen;

    localparam int CH = 4;
    localparam int CW = 8;
`ifdef PULSE_GEN_REG_OUT_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH*CW-1:0] cfg_width = '0;
    logic [CH*CW-1:0] cfg_period = '0;
    logic [CH-1:0] cfg_mode = '0;
    logic [CH-1:0] start = '0;
    logic [CH-1:0] stop = '0;
    logic [CH-1:0] pulse;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .pulse      (pulse),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Reference model: a channel is "active" from its accepted start edge t0;
    // during the interval after edge n, elapsed d = n - t0, pulse = d mod P < W.
    int   edge_n;
    int   m_t0 [CH];
    int   m_w  [CH];
    int   m_p  [CH];
    int   m_de [CH];
    bit   m_act [CH];
    bit   m_mode [CH];
    logic [CH-1:0] c_pulse, c_busy, c_done;
    logic [CH-1:0] e_pulse, e_busy, e_done;
    logic [CH-1:0] pv_pulse, pv_busy, pv_done;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            edge_n = 0;
            for (int c = 0; c < CH; c++) begin
                m_act[c] = 1'b0;
                m_de[c]  = -1;
            end
            c_pulse = '0; c_busy = '0; c_done = '0;
            e_pulse = '0; e_busy = '0; e_done = '0;
        end else begin
            edge_n++;
            pv_pulse = c_pulse; pv_busy = c_busy; pv_done = c_done;
            for (int c = 0; c < CH; c++) begin
                int wv;
                int pv;
                bit ending;
                ending = m_act[c] && !m_mode[c] && (edge_n - m_t0[c] == m_p[c]);
                if (m_act[c] && stop[c]) begin
                    m_act[c] = 1'b0;
                end else begin
                    if (ending) begin
                        m_act[c] = 1'b0;
                        m_de[c]  = edge_n;
                    end
                    wv = int'(cfg_width[c*CW +: CW]);
                    pv = int'(cfg_period[c*CW +: CW]);
                    if (pv < wv) pv = wv;
                    if (!m_act[c] && start[c] && !stop[c] && wv != 0) begin
                        m_act[c]  = 1'b1;
                        m_t0[c]   = edge_n;
                        m_w[c]    = wv;
                        m_p[c]    = pv;
                        m_mode[c] = cfg_mode[c];
                    end
                end
                c_busy[c]  = m_act[c];
                c_pulse[c] = 1'b0;
                if (m_act[c])
                    c_pulse[c] = ((edge_n - m_t0[c]) % m_p[c]) < m_w[c];
                c_done[c]  = (m_de[c] == edge_n);
            end
            if (OFS == 1) begin
                e_pulse = pv_pulse; e_busy = pv_busy; e_done = pv_done;
            end else begin
                e_pulse = c_pulse; e_busy = c_busy; e_done = c_done;
            end
        end
    end

    task automatic test_reset();
        cfg_width[0 +: CW] = 8'd3;
        cfg_period[0 +: CW] = 8'd8;
        cfg_mode[0] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            checks++;
            if ({pulse, busy, done} !== {e_pulse, e_busy, e_done}) begin
                errors++;
                $display("FAIL reset_pre e=%0d got p%b b%b d%b want p%b b%b d%b",
                         edge_n, pulse, busy, done, e_pulse, e_busy, e_done);
            end
            start[0] = (k == 0);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pulse, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_async got p%b b%b d%b want all 0", pulse, busy, done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checks++;
            if ({pulse, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_post e=%0d got p%b b%b d%b want all 0",
                         edge_n, pulse, busy, done);
            end
        end
        cfg_mode = '0;
    endtask

    task automatic test_one_shot();
        cfg_width[0 +: CW] = 8'd4;
        cfg_period[0 +: CW] = 8'd10;
        cfg_mode[0] = 1'b0;
        for (int k = 0; k < 18; k++) begin
            int d;
            @(negedge clock);
            d = k - 1 - OFS;
            checks++;
            if (pulse[0] !== (d >= 0 && d < 4) || busy[0] !== (d >= 0 && d < 10)
                || done[0] !== (d == 10)) begin
                errors++;
                $display("FAIL one_shot d=%0d got p%b b%b d%b want p%b b%b d%b", d,
                         pulse[0], busy[0], done[0], d >= 0 && d < 4,
                         d >= 0 && d < 10, d == 10);
            end
            start[0] = (k == 0);
        end
    endtask

    task automatic test_continuous();
        cfg_width[CW +: CW] = 8'd2;
        cfg_period[CW +: CW] = 8'd5;
        cfg_mode[1] = 1'b1;
        for (int k = 0; k < 22; k++) begin
            int d;
            logic ep;
            @(negedge clock);
            d  = k - 1 - OFS;
            ep = (d >= 0) && ((d % 5) < 2);
            checks++;
            if (pulse[1] !== ep || busy[1] !== (d >= 0) || done[1] !== 1'b0) begin
                errors++;
                $display("FAIL continuous d=%0d got p%b b%b d%b want p%b b%b d0", d,
                         pulse[1], busy[1], done[1], ep, d >= 0);
            end
            start[1] = (k == 0);
            stop[1]  = (k == 21);
        end
        @(negedge clock);
        stop = '0;
        cfg_mode = '0;
    endtask

    task automatic test_edges();
        cfg_width[2*CW +: CW] = 8'd0;
        cfg_period[2*CW +: CW] = 8'd5;
        cfg_width[3*CW +: CW] = 8'd6;
        cfg_period[3*CW +: CW] = 8'd3;
        cfg_mode[3] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            checks++;
            if ({pulse, busy, done} !== {e_pulse, e_busy, e_done}
                || (k >= 2 + OFS && pulse[3] !== 1'b1) || busy[2] !== 1'b0) begin
                errors++;
                $display("FAIL edges_w0_clamp e=%0d got p%b b%b d%b want p%b b%b d%b",
                         edge_n, pulse, busy, done, e_pulse, e_busy, e_done);
            end
            start[2] = (k == 0);
            start[3] = (k == 0);
            stop[3]  = (k == 23);
        end
        @(negedge clock);
        stop = '0;
        cfg_mode = '0;
        cfg_width[0 +: CW] = 8'd255;
        cfg_period[0 +: CW] = 8'd255;
        for (int k = 0; k < 262; k++) begin
            int d;
            @(negedge clock);
            d = k - 1 - OFS;
            checks++;
            if ({pulse, busy, done} !== {e_pulse, e_busy, e_done}
                || pulse[0] !== (d >= 0 && d < 255) || done[0] !== (d == 255)) begin
                errors++;
                $display("FAIL edges_max d=%0d got p%b b%b d%b want p%b b%b d%b",
                         d, pulse, busy, done, e_pulse, e_busy, e_done);
            end
            start[0] = (k == 0);
        end
    endtask

    task automatic test_races();
        cfg_width[2*CW +: CW] = 8'd5;
        cfg_period[2*CW +: CW] = 8'd9;
        cfg_width[1*CW +: CW] = 8'd3;
        cfg_period[1*CW +: CW] = 8'd6;
        for (int k = 0; k < 20; k++) begin
            int d;
            @(negedge clock);
            d = k - 1 - OFS;
            checks++;
            if ({pulse, busy, done} !== {e_pulse, e_busy, e_done}
                || pulse[2] !== (d >= 0 && d < 3) || done[2] !== 1'b0
                || busy[3] !== 1'b0) begin
                errors++;
                $display("FAIL races e=%0d got p%b b%b d%b want p%b b%b d%b",
                         edge_n, pulse, busy, done, e_pulse, e_busy, e_done);
            end
            start[2] = (k == 0);
            stop[2]  = (k == 3);
            start[3] = (k == 1);
            stop[3]  = (k == 1);
            start[1] = (k == 0) || (k == 3) || (k == 5);
        end
        start = '0;
        stop = '0;
    endtask

    task automatic test_back_to_back();
        cfg_width[0 +: CW] = 8'd2;
        cfg_period[0 +: CW] = 8'd3;
        for (int k = 0; k < 16; k++) begin
            int d;
            @(negedge clock);
            d = k - 1 - OFS;
            checks++;
            if ({pulse, busy, done} !== {e_pulse, e_busy, e_done}
                || done[0] !== (d > 0 && d % 3 == 0)
                || busy[0] !== (d >= 0 && d < 12)) begin
                errors++;
                $display("FAIL back_to_back d=%0d got p%b b%b d%b want p%b b%b d%b",
                         d, pulse, busy, done, e_pulse, e_busy, e_done);
            end
            start[0] = (k < 10);
        end
        start = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            checks++;
            if ({pulse, busy, done} !== {e_pulse, e_busy, e_done}) begin
                errors++;
                $display("FAIL random e=%0d got p%b b%b d%b want p%b b%b d%b",
                         edge_n, pulse, busy, done, e_pulse, e_busy, e_done);
            end
            for (int c = 0; c < CH; c++) begin
                cfg_width[c*CW +: CW]  = CW'($urandom_range(0, 7));
                cfg_period[c*CW +: CW] = CW'($urandom_range(0, 12));
                cfg_mode[c] = 1'($urandom_range(0, 1));
                start[c] = ($urandom_range(0, 3) == 0);
                stop[c]  = ($urandom_range(0, 15) == 0);
            end
        end
        start = '0;
        stop = '0;
    endtask

    initial begin
        #12 reset_n = 1'b1;
        test_reset();
        test_one_shot();
        test_continuous();
        test_edges();
        test_races();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
